// File: rtl/qtcore_seq_pkg.sv
// qtcore_seq_pkg: state encoding and sizing constants shared by the scan sequencer
package qtcore_seq_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_CHAIN_LEN = 152;
  localparam int DEF_RUN_LIMIT = 255;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LD_WAIT, ST_LD_SHIFT, ST_RUN, ST_DP_SHIFT, ST_DP_WAIT, ST_DONE
  } state_t;
endpackage

// File: rtl/qtcore_byte_shifter.sv
// qtcore_byte_shifter: parallel-load MSB-first byte shifter with bit counter, shared by load and dump paths
module qtcore_byte_shifter
  import qtcore_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic sin,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] q,
  output logic last_bit
);
  logic [2:0] cnt;
  assign last_bit = &cnt;
  always_ff @(posedge clk)
    if (rst) begin
      q <= '0;
      cnt <= '0;
    end else if (load) begin
      q <= din;
      cnt <= '0;
    end else if (shift) begin
      q <= {q[BYTE_W-2:0], sin};
      cnt <= cnt + 3'd1;
    end
endmodule

// File: rtl/qtcore_scan_sequencer.sv
// qtcore_scan_sequencer: scan load, run and optional chain readback (SCAN_READBACK_EN) sequencer for the qtcore
module qtcore_scan_sequencer
  import qtcore_seq_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int RUN_LIMIT = DEF_RUN_LIMIT,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [BYTE_W-1:0] load_data,
  input  logic load_valid,
  output logic load_ready,
  output logic scan_enable,
  output logic scan_in,
  input  logic scan_out,
  output logic proc_en,
  input  logic halt,
  output logic [BYTE_W-1:0] dump_data,
  output logic dump_valid,
  input  logic dump_ready,
  output logic busy,
  output logic done,
  output logic timeout
);
`ifdef SCAN_READBACK_EN
  localparam state_t RUN_EXIT = ST_DP_SHIFT;
`else
  localparam state_t RUN_EXIT = ST_DONE;
`endif
  state_t state, state_n;
  logic [CNT_W-1:0] bitcnt, runcnt;
  logic [BYTE_W-1:0] q;
  logic last_bit, tmo_r, idle, wd_hit, run_end;
  assign idle = state == ST_IDLE || state == ST_DONE;
  assign wd_hit = runcnt == CNT_W'(RUN_LIMIT - 1);
  assign run_end = state == ST_RUN && (halt || wd_hit);
  assign load_ready = state == ST_LD_WAIT;
  assign scan_enable = state == ST_LD_SHIFT || state == ST_DP_SHIFT;
  assign scan_in = state == ST_LD_SHIFT ? q[BYTE_W-1] : state == ST_DP_SHIFT && scan_out;
  assign proc_en = state == ST_RUN;
  assign busy = !idle;
  assign done = state == ST_DONE;
  assign timeout = tmo_r;
`ifdef SCAN_READBACK_EN
  assign dump_valid = state == ST_DP_WAIT;
  assign dump_data = dump_valid ? q : '0;
`else
  logic unused_ok;
  assign dump_valid = 1'b0;
  assign dump_data = '0;
  assign unused_ok = ^{dump_ready, q[BYTE_W-2:0]};
`endif
  qtcore_byte_shifter u_shift (
    .clk(clk),
    .rst(rst),
    .load(load_ready && load_valid),
    .shift(scan_enable),
    .sin(scan_out),
    .din(load_data),
    .q(q),
    .last_bit(last_bit)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: state_n = start ? ST_LD_WAIT : state;
      ST_LD_WAIT: state_n = load_valid ? ST_LD_SHIFT : state;
      ST_LD_SHIFT: state_n = !last_bit ? state : bitcnt + CNT_W'(1) == CNT_W'(CHAIN_LEN) ? ST_RUN : ST_LD_WAIT;
      ST_RUN: state_n = run_end ? RUN_EXIT : state;
`ifdef SCAN_READBACK_EN
      ST_DP_SHIFT: state_n = last_bit ? ST_DP_WAIT : state;
      ST_DP_WAIT: state_n = !dump_ready ? state : bitcnt == CNT_W'(CHAIN_LEN) ? ST_DONE : ST_DP_SHIFT;
`endif
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      bitcnt <= '0;
      runcnt <= '0;
      tmo_r <= 1'b0;
    end else begin
      state <= state_n;
      if (idle && start) begin
        bitcnt <= '0;
        runcnt <= '0;
        tmo_r <= 1'b0;
      end else if (scan_enable) begin
        bitcnt <= bitcnt + CNT_W'(1);
      end else if (proc_en) begin
        runcnt <= runcnt + CNT_W'(1);
        if (run_end) begin
          bitcnt <= '0;
          tmo_r <= !halt;
        end
      end
    end
endmodule

// File: tb/tb_qtcore_scan_sequencer.sv
// tb_qtcore_scan_sequencer: directed bench with a scan-chain model and stream/run scoreboard
module tb_qtcore_scan_sequencer;
  localparam int CL = 16;
  localparam int RL = 20;
  logic clk = 0, rst = 1, start = 0, load_valid = 0, halt = 0, dump_ready = 0;
  logic [7:0] load_data = '0, dump_data, prev_data = '0;
  logic load_ready, scan_enable, scan_in, scan_out, proc_en, dump_valid, busy, done, timeout;
  logic [CL-1:0] chain = '0;
  logic [15:0] outs;
  int checks = 0, errors = 0, cyc = 0, pe_cnt = 0, first_pe = -1, last_ld = -1, nshift = 0, ndump_shift = 0;
  bit free_shift = 0, hold_prev = 0;
  logic exp_bits[$];
  logic [7:0] exp_dump[$];
  qtcore_scan_sequencer #(.CHAIN_LEN(CL), .RUN_LIMIT(RL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .proc_en(proc_en), .halt(halt), .dump_data(dump_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .busy(busy), .done(done), .timeout(timeout)
  );
  always #5 clk = ~clk;
  assign scan_out = chain[CL-1];
  assign outs = {load_ready, scan_enable, scan_in, proc_en, dump_valid, dump_data, busy, done, timeout};
  always @(posedge clk) if (scan_enable) chain <= {chain[CL-2:0], scan_in};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired", nm);
  endtask
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (scan_enable) begin
      if (exp_bits.size() > 0) begin
        chk("scan_in", scan_in, exp_bits.pop_front());
        nshift++;
        if (exp_bits.size() == 0) last_ld = cyc;
      end else if (!free_shift) begin
`ifdef SCAN_READBACK_EN
        ndump_shift++;
`else
        chk("extra_shift", scan_enable, 0);
`endif
      end
    end
    if (proc_en) begin
      pe_cnt++;
      if (first_pe < 0) first_pe = cyc;
      chk("proc_en_with_scan", scan_enable, 0);
    end
    if (dump_valid) begin
      if (hold_prev) chk("dump_stable", dump_data, prev_data);
      if (dump_ready) begin
        if (exp_dump.size() > 0) chk("dump_data", dump_data, exp_dump.pop_front());
        else chk("dump_extra", dump_valid, 0);
        hold_prev = 0;
      end else begin
        hold_prev = 1;
        prev_data = dump_data;
      end
    end else hold_prev = 0;
  end
  task automatic send_byte(input logic [7:0] b);
    load_data = b;
    load_valid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (load_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail("load_ready");
  endtask
  task automatic run_phase(input int halt_at);
    int n = 0, hold = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) return;
      if (proc_en) begin
        n++;
        halt = n == halt_at;
      end else halt = 0;
      if (dump_valid) begin
        dump_ready = hold >= 3;
        hold = dump_ready ? 0 : hold + 1;
      end else dump_ready = 0;
    end
    fail("done");
  endtask
  task automatic do_seq(input logic [7:0] b0, input logic [7:0] b1, input int gap, input int halt_at,
                        input int exp_pe, input logic exp_to);
    logic [15:0] w = {b0, b1};
    @(posedge clk);
    #1;
    for (int i = 15; i >= 0; i--) exp_bits.push_back(w[i]);
`ifdef SCAN_READBACK_EN
    exp_dump.push_back(b0);
    exp_dump.push_back(b1);
`endif
    pe_cnt = 0; first_pe = -1; last_ld = -1; nshift = 0; ndump_shift = 0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    chk("start_state", {done, timeout, busy, load_ready}, 4'b0011);
    @(posedge clk);
    #1;
    send_byte(b0);
    if (gap > 0) begin
      load_valid = 0;
      for (int i = 0; i < 60 && !load_ready; i++) @(negedge clk);
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        chk("stall_idle", {scan_enable, load_ready}, 2'b01);
      end
      @(posedge clk);
      #1;
    end
    send_byte(b1);
    load_valid = 0;
    run_phase(halt_at);
    chk("bits_shifted", nshift, 16);
    chk("proc_after_load", first_pe - last_ld, 1);
    chk("run_cycles", pe_cnt, exp_pe);
    chk("chain", chain, w);
    chk("end_flags", {done, timeout, busy, proc_en}, {1'b1, exp_to, 2'b00});
`ifdef SCAN_READBACK_EN
    chk("dump_shifts", ndump_shift, 16);
    chk("dump_left", exp_dump.size(), 0);
`endif
    repeat (3) @(negedge clk);
    chk("done_held", {done, timeout}, {1'b1, exp_to});
  endtask
  task automatic reset_in(input bit in_run);
    bit hit = 0;
    free_shift = 1;
    @(posedge clk);
    #1;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    load_data = 8'hFF;
    load_valid = 1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = in_run ? proc_en : scan_enable;
    end
    if (!hit) fail(in_run ? "reach_run" : "reach_shift");
    rst = 1;
    @(negedge clk);
    chk(in_run ? "rst_in_run" : "rst_in_shift", outs, 0);
    @(posedge clk);
    #1;
    rst = 0;
    load_valid = 0;
    @(negedge clk);
    chk("idle_after_rst", outs, 0);
    free_shift = 0;
  endtask
  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", outs, 0);
    @(posedge clk);
    #1;
    rst = 0;
    do_seq(8'hA5, 8'h3C, 0, 10, 10, 0);
    chk("pin_chain", chain, 16'hA53C);
    do_seq(8'hC3, 8'h96, 5, 0, RL, 1);
    reset_in(0);
    reset_in(1);
    do_seq(8'hA5, 8'h3C, 0, RL, RL, 0);
    chk("pin_chain2", chain, 16'hA53C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
